// File: rtl/instruct_decode.sv
// rtl/instruct_decode.sv - LEGv8 instruction decode stage with in-ID branch resolution
//
// Decodes the IF/ID instruction, reads the 31-entry register file (X31 reads
// as zero), resolves every branch combinationally, and registers operands and
// control into the ID/EX pipeline register.
//
// Ports:
//   clk, reset                       pipeline clock, synchronous active-high reset
//   instruct_in, addr_ID_in          instruction and its address from IF/ID
//   flags_in                         {N,Z,C,V} from the flag forwarding unit
//   wb_reg_en/addr/data              register-file write-back port
//   fwd_ex_*, fwd_mem_*              EX/MEM results used for branch operands
//   addr_sel_out, branch_target,
//   flush_out                        redirect and squash back to IF (combinational)
//   rd1_out, rd2_out, imm_out,
//   addr_EX_out, dest_out,
//   alu_op_out, alu_src_out,
//   mem_read_out, mem_write_out,
//   reg_write_out, set_flags_out     registered ID/EX contents
module instruct_decode (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruct_in,
  input  logic [63:0] addr_ID_in,
  input  logic [3:0]  flags_in,
  input  logic        wb_reg_en,
  input  logic [4:0]  wb_reg_addr,
  input  logic [63:0] wb_data,
  input  logic        fwd_ex_en,
  input  logic [4:0]  fwd_ex_addr,
  input  logic [63:0] fwd_ex_data,
  input  logic        fwd_mem_en,
  input  logic [4:0]  fwd_mem_addr,
  input  logic [63:0] fwd_mem_data,
  output logic        addr_sel_out,
  output logic [63:0] branch_target,
  output logic        flush_out,
  output logic [63:0] rd1_out,
  output logic [63:0] rd2_out,
  output logic [63:0] imm_out,
  output logic [63:0] addr_EX_out,
  output logic [4:0]  dest_out,
  output logic [2:0]  alu_op_out,
  output logic        alu_src_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic        reg_write_out,
  output logic        set_flags_out
);

  localparam logic [10:0] OP_ADDS = 11'h558;
  localparam logic [10:0] OP_SUBS = 11'h758;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_EOR  = 11'h650;
  localparam logic [10:0] OP_LSR  = 11'h69A;
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  localparam logic [10:0] OP_BR   = 11'h6B0;
  localparam logic [9:0]  OP_ADDI = 10'h244;
  localparam logic [7:0]  OP_BC   = 8'h54;
  localparam logic [7:0]  OP_CBZ  = 8'hB4;
  localparam logic [5:0]  OP_B    = 6'h05;
  localparam logic [5:0]  OP_BL   = 6'h25;
  localparam logic [3:0]  COND_LT = 4'hB;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_XOR  = 3'b110;
  localparam logic [2:0] ALU_LSR  = 3'b111;

  // Instruction fields
  logic [4:0] rn, rm, rt;
  assign rn = instruct_in[9:5];
  assign rm = instruct_in[20:16];
  assign rt = instruct_in[4:0];

  logic is_addi, is_adds, is_subs, is_and, is_eor, is_lsr;
  logic is_ldur, is_stur, is_b, is_bl, is_bc, is_cbz, is_br;
  assign is_addi = (instruct_in[31:22] == OP_ADDI);
  assign is_adds = (instruct_in[31:21] == OP_ADDS);
  assign is_subs = (instruct_in[31:21] == OP_SUBS);
  assign is_and  = (instruct_in[31:21] == OP_AND);
  assign is_eor  = (instruct_in[31:21] == OP_EOR);
  assign is_lsr  = (instruct_in[31:21] == OP_LSR);
  assign is_ldur = (instruct_in[31:21] == OP_LDUR);
  assign is_stur = (instruct_in[31:21] == OP_STUR);
  assign is_br   = (instruct_in[31:21] == OP_BR);
  assign is_bc   = (instruct_in[31:24] == OP_BC);
  assign is_cbz  = (instruct_in[31:24] == OP_CBZ);
  assign is_b    = (instruct_in[31:26] == OP_B);
  assign is_bl   = (instruct_in[31:26] == OP_BL);

  // Word offsets of the two branch formats, already scaled to bytes
  logic [63:0] off26, off19;
  assign off26 = {{36{instruct_in[25]}}, instruct_in[25:0], 2'b00};
  assign off19 = {{43{instruct_in[23]}}, instruct_in[23:5], 2'b00};

  // Register file X0..X30; X31 is not stored
  logic [63:0] regs_q [0:30];
  logic [63:0] regs_d [0:30];

  always_comb begin
    regs_d = regs_q;
    if (wb_reg_en && wb_reg_addr != 5'd31) regs_d[wb_reg_addr] = wb_data;
  end

  // Read ports with write-through so a same-cycle write-back is visible
  logic [4:0]  rd2_addr;
  logic [63:0] rd1_val, rd2_val;
  assign rd2_addr = (is_stur || is_cbz) ? rt : rm;

  always_comb begin
    rd1_val = '0;
    rd2_val = '0;
    if (rn != 5'd31)
      rd1_val = (wb_reg_en && wb_reg_addr == rn) ? wb_data : regs_q[rn];
    if (rd2_addr != 5'd31)
      rd2_val = (wb_reg_en && wb_reg_addr == rd2_addr) ? wb_data : regs_q[rd2_addr];
  end

  // Branch operand: BR tests Rn, CBZ tests Rt; the youngest producer wins
  logic [4:0]  bop_addr;
  logic [63:0] bop_val;
  assign bop_addr = is_br ? rn : rt;

  always_comb begin
    bop_val = is_br ? rd1_val : rd2_val;
    if (fwd_ex_en && fwd_ex_addr != 5'd31 && fwd_ex_addr == bop_addr)
      bop_val = fwd_ex_data;
    else if (fwd_mem_en && fwd_mem_addr != 5'd31 && fwd_mem_addr == bop_addr)
      bop_val = fwd_mem_data;
  end

  logic        taken;
  logic [63:0] target;

  always_comb begin
    taken  = 1'b0;
    target = addr_ID_in + off19;
    if (is_b || is_bl) begin
      taken  = 1'b1;
      target = addr_ID_in + off26;
    end else if (is_br) begin
      taken  = 1'b1;
      target = bop_val;
    end else if (is_cbz) begin
      taken  = (bop_val == 64'd0);
    end else if (is_bc) begin
      // Only LT is implemented; every other condition falls through
      taken  = (instruct_in[3:0] == COND_LT) && (flags_in[3] != flags_in[0]);
    end
  end

  assign addr_sel_out  = taken;
  assign flush_out     = taken;
  assign branch_target = target;

  // Control decode
  logic [63:0] imm_d;
  logic [4:0]  dest_d;
  logic [2:0]  alu_op_d;
  logic        alu_src_d, mem_read_d, mem_write_d, reg_write_d, set_flags_d;

  always_comb begin
    imm_d       = '0;
    dest_d      = '0;
    alu_op_d    = ALU_PASS;
    alu_src_d   = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    reg_write_d = 1'b0;
    set_flags_d = 1'b0;
    if (is_addi) begin
      imm_d       = {52'd0, instruct_in[21:10]};
      alu_op_d    = ALU_ADD;
      alu_src_d   = 1'b1;
      reg_write_d = 1'b1;
      dest_d      = rt;
    end else if (is_adds || is_subs) begin
      alu_op_d    = is_adds ? ALU_ADD : ALU_SUB;
      reg_write_d = 1'b1;
      set_flags_d = 1'b1;
      dest_d      = rt;
    end else if (is_and || is_eor) begin
      alu_op_d    = is_and ? ALU_AND : ALU_XOR;
      reg_write_d = 1'b1;
      dest_d      = rt;
    end else if (is_lsr) begin
      imm_d       = {58'd0, instruct_in[15:10]};
      alu_op_d    = ALU_LSR;
      alu_src_d   = 1'b1;
      reg_write_d = 1'b1;
      dest_d      = rt;
    end else if (is_ldur || is_stur) begin
      imm_d       = {{55{instruct_in[20]}}, instruct_in[20:12]};
      alu_op_d    = ALU_ADD;
      alu_src_d   = 1'b1;
      mem_read_d  = is_ldur;
      mem_write_d = is_stur;
      reg_write_d = is_ldur;
      dest_d      = is_ldur ? rt : 5'd0;
    end else if (is_bl) begin
      // Link value travels as the immediate and passes straight through the ALU
      imm_d       = addr_ID_in + 64'd4;
      alu_src_d   = 1'b1;
      reg_write_d = 1'b1;
      dest_d      = 5'd30;
    end else if (is_b) begin
      imm_d = off26;
    end else if (is_cbz || is_bc) begin
      imm_d = off19;
    end
  end

  // ID/EX pipeline register
  logic [63:0] rd1_q, rd2_q, imm_q, addr_q;
  logic [4:0]  dest_q;
  logic [2:0]  alu_op_q;
  logic        alu_src_q, mem_read_q, mem_write_q, reg_write_q, set_flags_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 31; i++) regs_q[i] <= '0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      imm_q       <= '0;
      addr_q      <= '0;
      dest_q      <= '0;
      alu_op_q    <= '0;
      alu_src_q   <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      reg_write_q <= 1'b0;
      set_flags_q <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      rd1_q       <= rd1_val;
      rd2_q       <= rd2_val;
      imm_q       <= imm_d;
      addr_q      <= addr_ID_in;
      dest_q      <= dest_d;
      alu_op_q    <= alu_op_d;
      alu_src_q   <= alu_src_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      reg_write_q <= reg_write_d;
      set_flags_q <= set_flags_d;
    end
  end

  assign rd1_out       = rd1_q;
  assign rd2_out       = rd2_q;
  assign imm_out       = imm_q;
  assign addr_EX_out   = addr_q;
  assign dest_out      = dest_q;
  assign alu_op_out    = alu_op_q;
  assign alu_src_out   = alu_src_q;
  assign mem_read_out  = mem_read_q;
  assign mem_write_out = mem_write_q;
  assign reg_write_out = reg_write_q;
  assign set_flags_out = set_flags_q;

endmodule

// File: tb/tb_instruct_decode.sv
// tb/tb_instruct_decode.sv - self-checking bench for instruct_decode
module tb_instruct_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruct_in;
  logic [63:0] addr_ID_in;
  logic [3:0]  flags_in;
  logic        wb_reg_en;
  logic [4:0]  wb_reg_addr;
  logic [63:0] wb_data;
  logic        fwd_ex_en;
  logic [4:0]  fwd_ex_addr;
  logic [63:0] fwd_ex_data;
  logic        fwd_mem_en;
  logic [4:0]  fwd_mem_addr;
  logic [63:0] fwd_mem_data;
  logic        addr_sel_out, flush_out;
  logic [63:0] branch_target;
  logic [63:0] rd1_out, rd2_out, imm_out, addr_EX_out;
  logic [4:0]  dest_out;
  logic [2:0]  alu_op_out;
  logic        alu_src_out, mem_read_out, mem_write_out, reg_write_out, set_flags_out;

  instruct_decode dut (
    .clk(clk), .reset(reset), .instruct_in(instruct_in), .addr_ID_in(addr_ID_in),
    .flags_in(flags_in), .wb_reg_en(wb_reg_en), .wb_reg_addr(wb_reg_addr), .wb_data(wb_data),
    .fwd_ex_en(fwd_ex_en), .fwd_ex_addr(fwd_ex_addr), .fwd_ex_data(fwd_ex_data),
    .fwd_mem_en(fwd_mem_en), .fwd_mem_addr(fwd_mem_addr), .fwd_mem_data(fwd_mem_data),
    .addr_sel_out(addr_sel_out), .branch_target(branch_target), .flush_out(flush_out),
    .rd1_out(rd1_out), .rd2_out(rd2_out), .imm_out(imm_out), .addr_EX_out(addr_EX_out),
    .dest_out(dest_out), .alu_op_out(alu_op_out), .alu_src_out(alu_src_out),
    .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .reg_write_out(reg_write_out), .set_flags_out(set_flags_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic [63:0] imm;
    logic [63:0] addr;
    logic [4:0]  dest;
    logic [2:0]  alu_op;
    logic [4:0]  ctl;   // {alu_src, mem_read, mem_write, reg_write, set_flags}
  } idex_t;

  idex_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] model_rf [0:30];

  // Instruction encoders
  function automatic logic [31:0] enc_r(input logic [10:0] op, input logic [4:0] rd,
                                        input logic [4:0] rn, input logic [4:0] rm,
                                        input logic [5:0] sh);
    return {op, rm, sh, rn, rd};
  endfunction
  function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rn,
                                           input logic [11:0] imm);
    return {10'h244, imm, rn, rd};
  endfunction
  function automatic logic [31:0] enc_d(input logic [10:0] op, input logic [4:0] rt,
                                        input logic [4:0] rn, input logic [8:0] imm);
    return {op, imm, 2'b00, rn, rt};
  endfunction
  function automatic logic [31:0] enc_cbz(input logic [4:0] rt, input logic [18:0] imm);
    return {8'hB4, imm, rt};
  endfunction
  function automatic logic [31:0] enc_bc(input logic [3:0] cond, input logic [18:0] imm);
    return {8'h54, imm, 1'b0, cond};
  endfunction
  function automatic logic [31:0] enc_br(input logic [4:0] rn);
    return {11'h6B0, 5'd31, 6'd0, rn, 5'd0};
  endfunction

  // Reference register-file read, including same-cycle write-through
  function automatic logic [63:0] rf(input logic [4:0] a);
    if (a == 5'd31) return 64'd0;
    if (wb_reg_en && wb_reg_addr == a) return wb_data;
    return model_rf[a];
  endfunction

  function automatic idex_t mk(input logic [63:0] rd1, input logic [63:0] rd2,
                               input logic [63:0] imm, input logic [63:0] addr,
                               input logic [4:0] dest, input logic [2:0] alu,
                               input logic [4:0] ctl);
    return {rd1, rd2, imm, addr, dest, alu, ctl};
  endfunction

  function automatic idex_t snap();
    return {rd1_out, rd2_out, imm_out, addr_EX_out, dest_out, alu_op_out,
            alu_src_out, mem_read_out, mem_write_out, reg_write_out, set_flags_out};
  endfunction

  task automatic drive(input logic [31:0] ins, input logic [63:0] a);
    instruct_in = ins;
    addr_ID_in  = a;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) for (int i = 0; i < 31; i++) model_rf[i] = 64'd0;
    else if (wb_reg_en && wb_reg_addr != 5'd31) model_rf[wb_reg_addr] = wb_data;
    #1;
  endtask

  task automatic idle_ports();
    flags_in = 4'd0;
    wb_reg_en = 1'b0;  wb_reg_addr = 5'd0;  wb_data = 64'd0;
    fwd_ex_en = 1'b0;  fwd_ex_addr = 5'd0;  fwd_ex_data = 64'd0;
    fwd_mem_en = 1'b0; fwd_mem_addr = 5'd0; fwd_mem_data = 64'd0;
  endtask

  task automatic test_reset();
    idex_t got, exp;
    reset = 1'b1;
    idle_ports();
    drive(32'h0, 64'h0);
    tick();
    tick();
    got = snap();
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL reset_state got=%h exp=0", got);
    end
    reset = 1'b0;
    drive(32'h0, 64'h0);
    checks++;
    if (addr_sel_out !== 1'b0 || flush_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_nop_branch got sel=%b flush=%b exp 0 0", addr_sel_out, flush_out);
    end
    exp_q.push_back('0);
    tick();
    got = snap(); exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_nop_idex got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_addi();
    idex_t got, exp;
    drive(enc_addi(5'd1, 5'd31, 12'd5), 64'h10);
    exp_q.push_back(mk(64'd0, rf(5'd0), 64'd5, 64'h10, 5'd1, 3'b010, 5'b10010));
    checks++;
    if (addr_sel_out !== 1'b0 || flush_out !== 1'b0) begin
      errors++;
      $display("FAIL addi_branch got sel=%b flush=%b exp 0 0", addr_sel_out, flush_out);
    end
    tick();
    got = snap(); exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL addi_idex got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_write_through();
    idex_t got, exp;
    for (int i = 0; i < 2; i++) begin
      wb_reg_en = 1'b1;
      if (i == 0) begin
        wb_reg_addr = 5'd2; wb_data = 64'hDEAD;
        drive(enc_r(11'h558, 5'd3, 5'd2, 5'd2, 6'd0), 64'h14);
        exp_q.push_back(mk(64'hDEAD, 64'hDEAD, 64'd0, 64'h14, 5'd3, 3'b010, 5'b00011));
      end else begin
        // A write aimed at X31 must not leak through the read port
        wb_reg_addr = 5'd31; wb_data = 64'h1234;
        drive(enc_r(11'h758, 5'd4, 5'd31, 5'd2, 6'd0), 64'h18);
        exp_q.push_back(mk(64'd0, 64'hDEAD, 64'd0, 64'h18, 5'd4, 3'b011, 5'b00011));
      end
      tick();
      got = snap(); exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL write_through_%0d got=%h exp=%h", i, got, exp);
      end
    end
    wb_reg_en = 1'b0;
  endtask

  task automatic test_cbz();
    idex_t got, exp;
    logic  exp_tk;
    for (int i = 0; i < 6; i++) begin
      wb_reg_en    = (i == 1); wb_reg_addr = 5'd4; wb_data = 64'd9;
      fwd_ex_en    = (i == 0 || i == 1 || i == 3);
      fwd_ex_addr  = 5'd4;
      fwd_ex_data  = (i == 1) ? 64'd0 : 64'd7;
      fwd_mem_en   = (i >= 2 && i != 4);
      fwd_mem_addr = (i == 5) ? 5'd5 : 5'd4;
      fwd_mem_data = 64'd0;
      exp_tk       = (i == 1 || i == 2);
      drive(enc_cbz(5'd4, 19'h7FFFE), 64'h40);
      exp_q.push_back(mk(rf(5'd30), rf(5'd4), 64'hFFFF_FFFF_FFFF_FFF8, 64'h40,
                         5'd0, 3'b000, 5'b00000));
      checks++;
      if (addr_sel_out !== exp_tk || flush_out !== exp_tk ||
          (exp_tk && branch_target !== 64'h38)) begin
        errors++;
        $display("FAIL cbz_branch_%0d got sel=%b flush=%b tgt=%h exp sel=%b tgt=38",
                 i, addr_sel_out, flush_out, branch_target, exp_tk);
      end
      tick();
      got = snap(); exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL cbz_idex_%0d got=%h exp=%h", i, got, exp);
      end
    end
    idle_ports();
  endtask

  task automatic test_blt();
    idex_t got, exp;
    logic  exp_tk;
    logic [3:0] fl [0:4];
    fl[0] = 4'b1000; fl[1] = 4'b1001; fl[2] = 4'b0001; fl[3] = 4'b0000; fl[4] = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      flags_in = fl[i];
      exp_tk   = (i == 0 || i == 2);
      // Last entry is B.EQ with Z set: conditions other than LT never branch
      drive(enc_bc((i == 4) ? 4'h0 : 4'hB, 19'd3), 64'h100);
      exp_q.push_back(mk(rf(5'd3), rf(5'd0), 64'd12, 64'h100, 5'd0, 3'b000, 5'b00000));
      checks++;
      if (addr_sel_out !== exp_tk || flush_out !== exp_tk ||
          (exp_tk && branch_target !== 64'h10C)) begin
        errors++;
        $display("FAIL blt_branch_%0d got sel=%b flush=%b tgt=%h exp sel=%b tgt=10c",
                 i, addr_sel_out, flush_out, branch_target, exp_tk);
      end
      tick();
      got = snap(); exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL blt_idex_%0d got=%h exp=%h", i, got, exp);
      end
    end
    flags_in = 4'd0;
  endtask

  task automatic test_bl_br();
    idex_t got, exp;
    logic [63:0] exp_tgt;
    for (int i = 0; i < 5; i++) begin
      idle_ports();
      case (i)
        0: begin
          drive({6'h25, 26'd8}, 64'h20);
          exp_tgt = 64'h40;
          exp_q.push_back(mk(rf(5'd0), rf(5'd0), 64'h24, 64'h20, 5'd30, 3'b000, 5'b10010));
        end
        1: begin
          fwd_ex_en = 1'b1; fwd_ex_addr = 5'd5; fwd_ex_data = 64'h999;
          fwd_mem_en = 1'b1; fwd_mem_addr = 5'd30; fwd_mem_data = 64'h24;
          drive(enc_br(5'd30), 64'h44);
          exp_tgt = 64'h24;
          exp_q.push_back(mk(rf(5'd30), 64'd0, 64'd0, 64'h44, 5'd0, 3'b000, 5'b00000));
        end
        2: begin
          fwd_ex_en = 1'b1; fwd_ex_addr = 5'd30; fwd_ex_data = 64'h80;
          fwd_mem_en = 1'b1; fwd_mem_addr = 5'd30; fwd_mem_data = 64'h24;
          drive(enc_br(5'd30), 64'h48);
          exp_tgt = 64'h80;
          exp_q.push_back(mk(rf(5'd30), 64'd0, 64'd0, 64'h48, 5'd0, 3'b000, 5'b00000));
        end
        3: begin
          wb_reg_en = 1'b1; wb_reg_addr = 5'd30; wb_data = 64'h300;
          drive(enc_br(5'd30), 64'h4C);
          exp_tgt = 64'h300;
          exp_q.push_back(mk(64'h300, 64'd0, 64'd0, 64'h4C, 5'd0, 3'b000, 5'b00000));
        end
        default: begin
          drive({6'h05, 26'h3FF_FFFF}, 64'h200);
          exp_tgt = 64'h1FC;
          exp_q.push_back(mk(64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h200,
                             5'd0, 3'b000, 5'b00000));
        end
      endcase
      checks++;
      if (addr_sel_out !== 1'b1 || flush_out !== 1'b1 || branch_target !== exp_tgt) begin
        errors++;
        $display("FAIL bl_br_branch_%0d got sel=%b flush=%b tgt=%h exp 1 1 tgt=%h",
                 i, addr_sel_out, flush_out, branch_target, exp_tgt);
      end
      tick();
      got = snap(); exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL bl_br_idex_%0d got=%h exp=%h", i, got, exp);
      end
    end
    idle_ports();
  endtask

  task automatic test_back_to_back();
    idex_t got, exp;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: begin
          drive(enc_d(11'h7C2, 5'd5, 5'd2, 9'h1F8), 64'h50);
          exp_q.push_back(mk(rf(5'd2), 64'd0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h50,
                             5'd5, 3'b010, 5'b11010));
        end
        1: begin
          drive(enc_d(11'h7C0, 5'd4, 5'd2, 9'd16), 64'h54);
          exp_q.push_back(mk(rf(5'd2), rf(5'd4), 64'd16, 64'h54, 5'd0, 3'b010, 5'b10100));
        end
        2: begin
          drive(enc_r(11'h450, 5'd6, 5'd2, 5'd4, 6'd0), 64'h58);
          exp_q.push_back(mk(rf(5'd2), rf(5'd4), 64'd0, 64'h58, 5'd6, 3'b100, 5'b00010));
        end
        3: begin
          drive(enc_r(11'h650, 5'd7, 5'd4, 5'd2, 6'd0), 64'h5C);
          exp_q.push_back(mk(rf(5'd4), rf(5'd2), 64'd0, 64'h5C, 5'd7, 3'b110, 5'b00010));
        end
        4: begin
          drive(enc_r(11'h69A, 5'd8, 5'd2, 5'd0, 6'd4), 64'h60);
          exp_q.push_back(mk(rf(5'd2), rf(5'd0), 64'd4, 64'h60, 5'd8, 3'b111, 5'b10010));
        end
        default: begin
          drive(32'hFFFF_FFFF, 64'h64);
          exp_q.push_back(mk(64'd0, 64'd0, 64'd0, 64'h64, 5'd0, 3'b000, 5'b00000));
        end
      endcase
      checks++;
      if (addr_sel_out !== 1'b0 || flush_out !== 1'b0) begin
        errors++;
        $display("FAIL b2b_branch_%0d got sel=%b flush=%b exp 0 0", i, addr_sel_out, flush_out);
      end
      tick();
      got = snap(); exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL b2b_idex_%0d got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    idex_t got, exp;
    reset = 1'b1;
    drive({6'h05, 26'd1}, 64'h0);
    checks++;
    if (addr_sel_out !== 1'b1 || branch_target !== 64'h4) begin
      errors++;
      $display("FAIL reset_mid_branch got sel=%b tgt=%h exp 1 tgt=4", addr_sel_out, branch_target);
    end
    exp_q.push_back('0);
    tick();
    got = snap(); exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_mid_idex got=%h exp=%h", got, exp);
    end
    reset = 1'b0;
    drive(enc_r(11'h558, 5'd9, 5'd2, 5'd4, 6'd0), 64'h60);
    exp_q.push_back(mk(rf(5'd2), rf(5'd4), 64'd0, 64'h60, 5'd9, 3'b010, 5'b00011));
    tick();
    got = snap(); exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_mid_rf_clear got=%h exp=%h", got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_addi();
    test_write_through();
    test_cbz();
    test_blt();
    test_bl_br();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
